// File: rtl/sseg_pkg.sv
// Shared digit codes, display words and FSM states for the BCD formatter and the 7-segment scan driver.
package sseg_pkg;

  localparam logic [3:0]  SEG_BLANK  = 4'hF;
  localparam logic [3:0]  SEG_H      = 4'hC;
  localparam logic [3:0]  SEG_I      = 4'hE;
  localparam logic [15:0] MSG_HI     = 16'hFFCE;
  localparam logic [15:0] DISP_BLANK = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_e;

  // Elaboration-time binary to 5-digit BCD, so thresholds compare directly against the BCD register.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the next left shift.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bcd_display_fmt.sv
// Sequential binary-to-BCD formatter feeding the 7-segment scan driver; shows "HI" above MAX_VAL.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module bcd_display_fmt
  import sseg_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [15:0]     display_data
);

  localparam logic [19:0] MAX_BCD = to_bcd(MAX_VAL);

  state_e          state_q, state_d;
  logic [IN_W-1:0] shreg_q, shreg_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     disp_q, disp_d;
  logic [19:0]     bcd_adj;
  logic [15:0]     fmt_val;

  for (genvar g = 0; g < 5; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    fmt_val = bcd_q[15:0];
`ifdef SSEG_LZB_EN
    // Blank from the left until the first nonzero digit; digit0 always stays numeric.
    if (bcd_q[15:12] == 4'd0) begin
      fmt_val[15:12] = SEG_BLANK;
      if (bcd_q[11:8] == 4'd0) begin
        fmt_val[11:8] = SEG_BLANK;
        if (bcd_q[7:4] == 4'd0) begin
          fmt_val[7:4] = SEG_BLANK;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin;
          bcd_d   = '0;
          cnt_d   = 5'(IN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        disp_d  = (bcd_q > MAX_BCD) ? MSG_HI : fmt_val;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= DISP_BLANK;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign display_data = disp_q;

endmodule

// File: doc/bcd_display_fmt.md
Name: bcd_display_fmt

Overview:
- Upstream feeder for the 7-segment scan driver: converts an unsigned binary value into the 4-nibble `display_data` word the driver consumes.
- Uses sequential shift-and-add-3 (double dabble), one bit per cycle.
- Applies an overflow message: "HI" in the two rightmost digits when value > 9999.
- Output is held stable between conversions so the scan driver never sees intermediate values.

Parameters:
- IN_W, 16, width of binary input; legal range 4..16.
- MAX_VAL, 9999, largest value shown numerically; above this, show the overflow message.

Ports:
- clk  input  1  system clock.
- clear  input  1  synchronous active-high reset.
- start  input  1  one-cycle request; honoured only in IDLE.
- bin  input  IN_W  unsigned value; sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `display_data` is updated.
- display_data  output  16  digit3 in [15:12] (leftmost) to digit0 in [3:0]; feeds the scan driver.

Behaviour:
- Interface: one clock `clk`; reset `clear` is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, display_data=16'hFFFF (all blank). Internal shift/BCD registers are zeroed.
- Digit codes:
  - 0-9 numeric.
  - 4'hC = H, 4'hE = I.
  - 4'hF = blank.
  - 4'hA is never produced.
- States:
  - IDLE: on start=1 at edge k, capture bin into shift reg, clear the 20-bit BCD reg, set bit counter to IN_W; go to SHIFT.
  - SHIFT: each edge, add 3 to every BCD nibble ≥5, then shift {bcd,shreg} left by 1 and decrement the counter. After IN_W edges (edge k+IN_W), go to FORMAT.
  - FORMAT: at edge k+IN_W+1, register display_data, pulse done=1, return to IDLE.
- Latency: start accepted at edge k; done high during the cycle after edge k+IN_W+1. Default total is 17 edges after start.
- busy: 1 in SHIFT and FORMAT, 0 in IDLE.
- start while busy: ignored, no queuing, no effect on the running conversion or on `bin` capture.
- start in the cycle done=1: accepted (state is IDLE). display_data keeps the old result until the new done.
- bin changes after capture: no effect on the running conversion.
- Formatting in FORMAT:
  - If the converted value > MAX_VAL (BCD digit4 ≠ 0, or value compare): display_data = 16'hFFCE.
  - Otherwise display_data = the low 4 BCD digits, with optional blanking.
- BCD register is 5 digits (20 bits), enough for 65535.
- clear mid-conversion: abort with no done pulse, busy=0, display_data=16'hFFFF.
- done is never asserted without a preceding accepted start.

Optional Feature:
- SSEG_LZB_EN (leading-zero blanking):
  - Defined: in FORMAT, leading zero digits of digit3..digit1 are replaced by 4'hF, scanning from digit3 down until the first nonzero. digit0 is always numeric, so 0 shows 16'hFFF0.
  - Undefined: all four digits are numeric (0 → 16'h0000).
  - The overflow message is unaffected either way.

Decomposition:
- Package `sseg_pkg`:
  - Digit-code constants: SEG_BLANK=4'hF, SEG_H=4'hC, SEG_I=4'hE.
  - MSG_HI=16'hFFCE and DISP_BLANK=16'hFFFF.
  - State enum {IDLE, SHIFT, FORMAT}.
  - Shared by this block and the scan driver.
- Sub-module `bcd_add3_digit`: combinational 4-bit "if ≥5 add 3" cell, instantiated 5×.
- Counter, FSM and formatting live in the top.

Test Plan:
- After clear, start with bin=1234 → busy for 17 cycles; done pulse once; display_data=16'h1234. No done before that.
- bin=0 → 16'hFFF0 with SSEG_LZB_EN, 16'h0000 without. bin=7 → 16'hFFF7 / 16'h0007.
- bin=9999 → 16'h9999. bin=10000 → 16'hFFCE. bin=65535 → 16'hFFCE.
- start=1 with bin=42 three cycles into a bin=1234 conversion → result 16'h1234, single done; then 42 is never shown.
- clear asserted at SHIFT cycle 5 → next cycle busy=0, display_data=16'hFFFF, no done. A subsequent start with bin=560 yields 16'hF560 (LZB) or 16'h0560 (no LZB).
- Back-to-back: start=1 held continuously with bin=1,2 alternating → a conversion every 18 cycles, display_data stable between done pulses.
